ws2812b_frame_ctrl: RTL

WS2812B_FRAME_CTRL -- requirements
Module: ws2812b_frame_ctrl

---
 rtl/ws2812b_frame_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ws2812b_frame_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : ws2812b_frame_ctrl                                         |
// | Description : WS2812B frame controller. Holds a pixel register file and  |
// |               serialises it MSB first as one frame plus a latch gap.     |
// |               Define WS2812B_AUTO_REFRESH_EN to add a periodic start.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module ws2812b_frame_ctrl #(
  parameter int LED_COUNT      = 8,
  parameter int TBIT           = 15,
  parameter int T0H            = 4,
  parameter int T1H            = 8,
  parameter int RESET_CYCLES   = 960,
  parameter int REFRESH_CYCLES = 12000000,
  localparam int c_addr_w      = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wr_en,
  input  logic [c_addr_w-1:0] wr_addr,
  input  logic [23:0]         wr_data,
  output logic                sig1,
  output logic                busy,
  output logic                frame_done
);

  localparam int c_pw = $clog2(TBIT + 1);
  localparam int c_lw = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [c_pw-1:0]     c_t0_last    = c_pw'(T0H - 1);
  localparam logic [c_pw-1:0]     c_t1_last    = c_pw'(T1H - 1);
  localparam logic [c_pw-1:0]     c_tbit_last  = c_pw'(TBIT - 1);
  localparam logic [c_lw-1:0]     c_latch_last = c_lw'(RESET_CYCLES - 1);
  localparam logic [c_addr_w-1:0] c_last_led   = c_addr_w'(LED_COUNT - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_high  = 3'd2;
  localparam logic [2:0] c_st_low   = 3'd3;
  localparam logic [2:0] c_st_latch = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [23:0]         r_pix [LED_COUNT];
  logic [23:0]         r_shift;
  logic [4:0]          r_bit_cnt;
  logic [c_addr_w-1:0] r_led_idx;
  logic [c_pw-1:0]     r_phase;
  logic [c_lw-1:0]     r_latch_cnt;
  logic                r_sig1;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_start;
  logic                w_sig1_next;
  logic                w_busy_next;
  logic                w_done_next;
  logic [c_pw-1:0]     w_high_last;
  logic                w_bit_end;
  logic [c_addr_w-1:0] w_next_idx;
  logic [c_addr_w-1:0] w_load_idx;
  logic [23:0]         w_load_pix;

`ifdef WS2812B_AUTO_REFRESH_EN
  localparam int c_rw = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [c_rw-1:0] c_refresh_last = c_rw'(REFRESH_CYCLES - 1);

  logic [c_rw-1:0] r_refresh_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
    end else if (r_refresh_cnt == c_refresh_last) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + c_rw'(1);
    end
  end

  // The FSM only honours a start in IDLE, so refresh ticks during a frame drop out.
  assign w_start = start | (r_refresh_cnt == c_refresh_last);
`else
  assign w_start = start;
`endif

  assign w_high_last = r_shift[23] ? c_t1_last : c_t0_last;
  assign w_bit_end   = (r_phase == c_tbit_last);
  assign w_next_idx  = r_led_idx + c_addr_w'(1);
  assign w_load_idx  = (r_state == c_st_load) ? '0 : w_next_idx;
  // A write landing on the very edge a pixel is loaded is forwarded, so it is not lost.
  assign w_load_pix  = (wr_en && (wr_addr == w_load_idx)) ? wr_data : r_pix[w_load_idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LED_COUNT; i++) begin
      if (!rst_n) begin
        r_pix[i] <= '0;
      end else if (wr_en && (wr_addr == c_addr_w'(i))) begin
        r_pix[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_sig1       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sig1       <= w_sig1_next;
      r_busy       <= w_busy_next;
      r_frame_done <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start) w_state_next = c_st_load;
      end
      c_st_load: begin
        w_state_next = c_st_high;
      end
      c_st_high: begin
        if (r_phase == w_high_last) w_state_next = c_st_low;
      end
      c_st_low: begin
        if (w_bit_end) begin
          if ((r_bit_cnt == 5'd0) && (r_led_idx == c_last_led)) begin
            w_state_next = c_st_latch;
          end else begin
            w_state_next = c_st_high;
          end
        end
      end
      c_st_latch: begin
        if (r_latch_cnt == c_latch_last) w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line stays aligned with r_state.
  always_comb begin
    w_sig1_next = (w_state_next == c_st_high);
    w_busy_next = (w_state_next != c_st_idle);
    w_done_next = (r_state == c_st_latch) && (w_state_next == c_st_idle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_led_idx   <= '0;
      r_phase     <= '0;
      r_latch_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_phase     <= '0;
          r_latch_cnt <= '0;
        end
        c_st_load: begin
          r_shift   <= w_load_pix;
          r_led_idx <= '0;
          r_bit_cnt <= 5'd23;
          r_phase   <= '0;
        end
        c_st_high: begin
          r_phase <= r_phase + c_pw'(1);
        end
        c_st_low: begin
          if (w_bit_end) begin
            r_phase <= '0;
            if (r_bit_cnt == 5'd0) begin
              if (r_led_idx != c_last_led) begin
                r_shift   <= w_load_pix;
                r_led_idx <= w_next_idx;
                r_bit_cnt <= 5'd23;
              end
            end else begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
            end
          end else begin
            r_phase <= r_phase + c_pw'(1);
          end
        end
        c_st_latch: begin
          if (r_latch_cnt == c_latch_last) begin
            r_latch_cnt <= '0;
          end else begin
            r_latch_cnt <= r_latch_cnt + c_lw'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sig1       = r_sig1;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire
